memory_stage: RTL
=================

# memory_stage

Fourth pipeline stage of the 5-stage CPU, directly downstream of the execute stage. It takes the registered ALU result, destination info and load/store controls, and performs the data-memory access over a request/`addr_ok`/`data_ok` SRAM-style bus. It aligns and extends load data, then presents a single valid result to write-back under a valid/allowin handshake. Non-memory instructions pass through in one cycle; memory instructions stall the stage until the bus completes.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; sampled on clk

Execute-stage side:
- exe_valid  in  1  execute stage presents an instruction
- mem_allowin  out  1  stage can accept an instruction this cycle
- exe_reg_en  in  1  instruction writes a GPR
- exe_mem_read  in  1  load
- exe_mem_write  in  1  store; never high together with exe_mem_read
- exe_mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- exe_load_signed  in  1  sign-extend byte/half loads
- exe_reg_waddr  in  5  destination GPR
- alu_result_reg  in  32  ALU result, or effective address for load/store
- exe_store_data  in  32  store source register value

Data bus side:
- data_req  out  1  request valid
- data_wr  out  1  1 = write
- data_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- data_wstrb  out  4  byte enables; 0 for reads
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid or write acknowledged
- data_rdata  in  32  read data

Write-back side:
- wb_allowin  in  1  write-back accepts this cycle
- mem_valid  out  1  result valid
- mem_reg_en  out  1  GPR write enable
- mem_reg_waddr  out  5  destination GPR
- mem_reg_wdata  out  32  final write data
- mem_misalign  out  1  access faulted; see Configuration

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DONE.
- mem_allowin = (state==IDLE) | (state==DONE & wb_allowin).
- Accept means exe_valid & mem_allowin. On accept, the stage latches all exe_* inputs and alu_result_reg.
- Accepted non-memory instruction: go to DONE with mem_reg_wdata = alu_result_reg.
- Accepted load/store: go to REQ.
- REQ state:
  - data_req=1, with addr, wr, wstrb and wdata driven from the latched values.
  - Stay in REQ until data_addr_ok, then go to WAIT.
  - data_req falls in the cycle after addr_ok.
- WAIT state:
  - On data_data_ok, go to DONE.
  - For a load, data_rdata is aligned and extended into mem_reg_wdata.
  - For a store, mem_reg_en is forced to 0.
- DONE state:
  - mem_valid=1.
  - If wb_allowin, either accept a new instruction (if exe_valid) or return to IDLE.
  - Otherwise hold all outputs stable.
- Load alignment, with off = addr[1:0]:
  - byte: data_rdata[8*off+7:8*off]
  - half: data_rdata[16*off[1]+15:16*off[1]]
  - sign- or zero-extend per exe_load_signed.
- Store byte lanes:
  - byte: wstrb = 4'b0001<<off, wdata = {4{sd[7:0]}}
  - half: wstrb = 4'b0011<<(2*off[1]), wdata = {2{sd[15:0]}}
  - word: wstrb = 4'b1111, wdata = sd
- data_data_ok seen outside WAIT is ignored. data_addr_ok seen outside REQ is ignored.
- Only one bus transaction is ever outstanding.

## Timing
- Reset values:
  - state = IDLE, hence mem_allowin=1.
  - mem_valid, mem_reg_en, mem_misalign, data_req, data_wr = 0.
  - data_addr, data_wstrb, data_wdata, mem_reg_waddr, mem_reg_wdata = 0.
- Reset mid-transaction abandons the access. The bus slave is reset by the same signal.
- Non-memory latency: accepted at edge N, mem_valid high in cycle N+1.
- Memory latency, best case:
  - accept at edge N;
  - data_req in cycle N+1 with addr_ok in N+1;
  - data_ok in N+2;
  - mem_valid in N+3.
  - Each extra slave wait cycle adds one.
- data_data_ok never arrives in the same cycle as its data_addr_ok.
- Back-to-back: in DONE with wb_allowin & exe_valid, the old result retires and the new instruction is latched on the same edge, with no bubble.
- All outputs are registered, except mem_allowin, which is combinational on state and wb_allowin.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Misaligned halves (off[0]=1) and misaligned words (off!=0) issue no bus request.
  - Such an instruction goes directly to DONE with mem_misalign=1 and mem_reg_en=0.
- Macro undefined:
  - mem_misalign is tied to 0.
  - Halves ignore off[0]; words ignore off entirely (the access is treated as aligned).

## Test plan
- Non-memory op: alu_result_reg=0x12345678, waddr=5 -> next cycle mem_valid=1, mem_reg_wdata=0x12345678, mem_reg_waddr=5, no data_req.
- Signed byte load, addr=0x1003, rdata=0x80AABBCC, addr_ok delayed 2 cycles -> data_addr=0x1000 held with data_req for 3 cycles, mem_reg_wdata=0xFFFFFF80.
- Half store, addr=0x2002, store data=0x0000BEEF -> wstrb=4'b1100, wdata=0xBEEFBEEF, wr=1, mem_reg_en=0 after data_ok.
- wb_allowin=0 for 3 cycles in DONE -> mem_allowin=0, outputs stable; then wb_allowin=1 with exe_valid -> next instruction latched the same edge.
- Reset asserted in WAIT, then a stray data_ok -> outputs at reset values, data_ok ignored, no mem_valid.
- Word load at addr=0x3001 -> with MEM_ALIGN_CHECK_EN: no data_req, mem_misalign=1; without the macro: data_addr=0x3000, mem_reg_wdata=data_rdata.

Source files
------------

// File: rtl/memory_stage_if.sv
// memory_stage_if: SRAM-style data bus between the memory stage and the data
// memory. A request is held until addr_ok; the response (read data or write
// acknowledge) follows later on data_ok.
interface memory_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // Pipeline side issues requests
    modport master (
        output data_req,
        output data_wr,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    // Memory side accepts requests and responds
    modport slave (
        input  data_req,
        input  data_wr,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: fourth stage of the 5-stage pipeline. Non-memory instructions
// pass through in one cycle; loads/stores issue one bus transaction, stall until
// data_ok, then present an aligned/extended result to write-back.
// Optional feature macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses are
// not issued and retire with mem_misalign=1 instead.
module memory_stage (
    input  logic                  clk,
    input  logic                  reset,
    // execute side
    input  logic                  exe_valid,
    output logic                  mem_allowin,
    input  logic                  exe_reg_en,
    input  logic                  exe_mem_read,
    input  logic                  exe_mem_write,
    input  logic [1:0]            exe_mem_size,
    input  logic                  exe_load_signed,
    input  logic [4:0]            exe_reg_waddr,
    input  logic [31:0]           alu_result_reg,
    input  logic [31:0]           exe_store_data,
    // data bus
    memory_stage_if.master        dbus,
    // write-back side
    input  logic                  wb_allowin,
    output logic                  mem_valid,
    output logic                  mem_reg_en,
    output logic [4:0]            mem_reg_waddr,
    output logic [31:0]           mem_reg_wdata,
    output logic                  mem_misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;

    // latched instruction fields used after acceptance
    logic        reg_en_q, reg_en_d;
    logic        mem_write_q, mem_write_d;
    logic [1:0]  size_q, size_d;
    logic        load_signed_q, load_signed_d;
    logic [31:0] addr_q, addr_d;

    // registered outputs
    logic        data_req_q, data_req_d;
    logic        data_wr_q, data_wr_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [3:0]  data_wstrb_q, data_wstrb_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_reg_en_q, mem_reg_en_d;
    logic [4:0]  mem_reg_waddr_q, mem_reg_waddr_d;
    logic [31:0] mem_reg_wdata_q, mem_reg_wdata_d;
    logic        mem_misalign_q, mem_misalign_d;

    logic        accept;
    logic        in_is_mem;
    logic [1:0]  in_off;
    logic        in_misalign;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign mem_allowin = (state_q == StIdle) | ((state_q == StDone) & wb_allowin);
    assign accept      = exe_valid & mem_allowin;
    assign in_is_mem   = exe_mem_read | exe_mem_write;
    assign in_off      = alu_result_reg[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    // Halves need off[0]==0, words (size 10/11) need off==0
    always_comb begin
        in_misalign = 1'b0;
        case (exe_mem_size)
            2'b00:   in_misalign = 1'b0;
            2'b01:   in_misalign = in_off[0];
            default: in_misalign = (in_off != 2'b00);
        endcase
    end
`else
    // Without the check every access is issued as if aligned
    assign in_misalign = 1'b0;
`endif

    // Byte-lane strobes and replicated write data for the incoming store
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = exe_store_data;
        case (exe_mem_size)
            2'b00: begin
                st_wstrb = 4'b0001 << in_off;
                st_wdata = {4{exe_store_data[7:0]}};
            end
            2'b01: begin
                // off[0] is ignored: a half always lands on lanes 1:0 or 3:2
                st_wstrb = in_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{exe_store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = exe_store_data;
            end
        endcase
    end

    // Select and extend the addressed byte/half of the returned read word
    always_comb begin
        ld_byte = dbus.data_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dbus.data_rdata[31:16] : dbus.data_rdata[15:0];
        case (size_q)
            2'b00:   ld_data = {{24{load_signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{load_signed_q & ld_half[15]}}, ld_half};
            default: ld_data = dbus.data_rdata;
        endcase
    end

    // Next-state logic: bus handshake progress, retirement and acceptance
    always_comb begin
        state_d         = state_q;
        reg_en_d        = reg_en_q;
        mem_write_d     = mem_write_q;
        size_d          = size_q;
        load_signed_d   = load_signed_q;
        addr_d          = addr_q;
        data_req_d      = data_req_q;
        data_wr_d       = data_wr_q;
        data_addr_d     = data_addr_q;
        data_wstrb_d    = data_wstrb_q;
        data_wdata_d    = data_wdata_q;
        mem_valid_d     = mem_valid_q;
        mem_reg_en_d    = mem_reg_en_q;
        mem_reg_waddr_d = mem_reg_waddr_q;
        mem_reg_wdata_d = mem_reg_wdata_q;
        mem_misalign_d  = mem_misalign_q;

        case (state_q)
            StIdle: begin
            end
            StReq: begin
                if (dbus.data_addr_ok) begin
                    state_d    = StWait;
                    data_req_d = 1'b0;
                end
            end
            StWait: begin
                if (dbus.data_data_ok) begin
                    state_d         = StDone;
                    mem_valid_d     = 1'b1;
                    mem_reg_en_d    = reg_en_q & ~mem_write_q;
                    mem_reg_wdata_d = mem_write_q ? addr_q : ld_data;
                end
            end
            StDone: begin
                // Retire; an accept below overrides this on the same edge
                if (wb_allowin) begin
                    state_d        = StIdle;
                    mem_valid_d    = 1'b0;
                    mem_reg_en_d   = 1'b0;
                    mem_misalign_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            reg_en_d        = exe_reg_en;
            mem_write_d     = exe_mem_write;
            size_d          = exe_mem_size;
            load_signed_d   = exe_load_signed;
            addr_d          = alu_result_reg;
            mem_reg_waddr_d = exe_reg_waddr;
            mem_misalign_d  = 1'b0;
            if (!in_is_mem) begin
                state_d         = StDone;
                mem_valid_d     = 1'b1;
                mem_reg_en_d    = exe_reg_en;
                mem_reg_wdata_d = alu_result_reg;
            end else if (in_misalign) begin
                state_d         = StDone;
                mem_valid_d     = 1'b1;
                mem_reg_en_d    = 1'b0;
                mem_misalign_d  = 1'b1;
                mem_reg_wdata_d = alu_result_reg;
            end else begin
                state_d      = StReq;
                mem_valid_d  = 1'b0;
                mem_reg_en_d = 1'b0;
                data_req_d   = 1'b1;
                data_wr_d    = exe_mem_write;
                data_addr_d  = {alu_result_reg[31:2], 2'b00};
                data_wstrb_d = exe_mem_write ? st_wstrb : 4'b0000;
                data_wdata_d = exe_mem_write ? st_wdata : 32'h0;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            reg_en_q        <= 1'b0;
            mem_write_q     <= 1'b0;
            size_q          <= 2'b00;
            load_signed_q   <= 1'b0;
            addr_q          <= 32'h0;
            data_req_q      <= 1'b0;
            data_wr_q       <= 1'b0;
            data_addr_q     <= 32'h0;
            data_wstrb_q    <= 4'h0;
            data_wdata_q    <= 32'h0;
            mem_valid_q     <= 1'b0;
            mem_reg_en_q    <= 1'b0;
            mem_reg_waddr_q <= 5'h0;
            mem_reg_wdata_q <= 32'h0;
            mem_misalign_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            reg_en_q        <= reg_en_d;
            mem_write_q     <= mem_write_d;
            size_q          <= size_d;
            load_signed_q   <= load_signed_d;
            addr_q          <= addr_d;
            data_req_q      <= data_req_d;
            data_wr_q       <= data_wr_d;
            data_addr_q     <= data_addr_d;
            data_wstrb_q    <= data_wstrb_d;
            data_wdata_q    <= data_wdata_d;
            mem_valid_q     <= mem_valid_d;
            mem_reg_en_q    <= mem_reg_en_d;
            mem_reg_waddr_q <= mem_reg_waddr_d;
            mem_reg_wdata_q <= mem_reg_wdata_d;
            mem_misalign_q  <= mem_misalign_d;
        end
    end

    assign dbus.data_req    = data_req_q;
    assign dbus.data_wr     = data_wr_q;
    assign dbus.data_addr   = data_addr_q;
    assign dbus.data_wstrb  = data_wstrb_q;
    assign dbus.data_wdata  = data_wdata_q;
    assign mem_valid        = mem_valid_q;
    assign mem_reg_en       = mem_reg_en_q;
    assign mem_reg_waddr    = mem_reg_waddr_q;
    assign mem_reg_wdata    = mem_reg_wdata_q;
    assign mem_misalign     = mem_misalign_q;

endmodule
